data_mem_arbiter: RTL and testbench

Arbitrates the single-port `data_mem` between the core datapath's load/store port and a debug/loader port. The core gets fixed priority with a bounded-starvation guarantee for the debug port. The debug port can lock the memory across a multi-cycle burst. The block asserts a stall to the core whenever the core requests and is not granted, so the core can hold `pc_reg` and suppress register-file writeback. It sits between the datapath's memory signals and the `data_mem` instance.

---
 rtl/data_mem_arbiter.sv | 116 +++++++++++
 tb/tb_data_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: zero-latency grant of data_mem to the core or debug port; a core that is not granted sees core_stall_o.
// Default is fixed core priority with a starvation counter. Define ARB_ROUND_ROBIN_EN for round-robin on contention.
module data_mem_arbiter #(
  parameter int AddressWidth = 10,
  parameter int StarveLimit  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    core_req_i,
  input  logic                    core_wr_en_i,
  input  logic [AddressWidth-1:0] core_addr_i,
  input  logic [31:0]             core_wr_data_i,
  input  logic [2:0]              core_funct3_i,
  output logic                    core_gnt_o,
  output logic                    core_stall_o,
  output logic [31:0]             core_r_data_o,
  input  logic                    dbg_req_i,
  input  logic                    dbg_lock_i,
  input  logic                    dbg_wr_en_i,
  input  logic [AddressWidth-1:0] dbg_addr_i,
  input  logic [31:0]             dbg_wr_data_i,
  input  logic [2:0]              dbg_funct3_i,
  output logic                    dbg_gnt_o,
  output logic [31:0]             dbg_r_data_o,
  output logic                    mem_r_en_o,
  output logic                    mem_wr_en_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wr_data_o,
  output logic [2:0]              mem_funct3_o,
  input  logic [31:0]             mem_r_data_i
);

  typedef enum logic [1:0] {IDLE, CORE, DBG, DBG_LOCK} state_t;

  state_t state, state_next;
  logic   core_gnt, dbg_gnt, contend, dbg_wins;

  assign contend = core_req_i & dbg_req_i;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the debug port is owed the next contended cycle.
  logic rr_dbg_next;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_dbg_next <= 1'b0;
    end else if (contend) begin
      rr_dbg_next <= core_gnt;
    end
  end

  assign dbg_wins = rr_dbg_next;
`else
  localparam logic [3:0] StarveMax = 4'(StarveLimit);
  logic [3:0] starve_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= 4'd0;
    end else if (!dbg_req_i || dbg_gnt) begin
      starve_cnt <= 4'd0;
    end else if (core_gnt && (starve_cnt != StarveMax)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign dbg_wins = (starve_cnt == StarveMax);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grants are forced low while reset is asserted so nothing reaches data_mem.
  always_comb begin
    core_gnt   = 1'b0;
    dbg_gnt    = 1'b0;
    state_next = IDLE;
    if (rst_ni) begin
      if (state == DBG_LOCK) begin
        dbg_gnt = dbg_req_i;
      end else if (contend) begin
        dbg_gnt  = dbg_wins;
        core_gnt = ~dbg_wins;
      end else begin
        core_gnt = core_req_i;
        dbg_gnt  = dbg_req_i;
      end
    end
    if (dbg_gnt && dbg_lock_i) begin
      state_next = DBG_LOCK;
    end else if (dbg_gnt) begin
      state_next = DBG;
    end else if (core_gnt) begin
      state_next = CORE;
    end
  end

  assign core_gnt_o   = core_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign core_stall_o = rst_ni & core_req_i & ~core_gnt;

  assign mem_wr_en_o   = (core_gnt & core_wr_en_i) | (dbg_gnt & dbg_wr_en_i);
  assign mem_r_en_o    = (core_gnt & ~core_wr_en_i) | (dbg_gnt & ~dbg_wr_en_i);
  assign mem_addr_o    = core_gnt ? core_addr_i    : (dbg_gnt ? dbg_addr_i    : '0);
  assign mem_wr_data_o = core_gnt ? core_wr_data_i : (dbg_gnt ? dbg_wr_data_i : 32'd0);
  assign mem_funct3_o  = core_gnt ? core_funct3_i  : (dbg_gnt ? dbg_funct3_i  : 3'd0);

  assign core_r_data_o = core_gnt ? mem_r_data_i : 32'd0;
  assign dbg_r_data_o  = dbg_gnt  ? mem_r_data_i : 32'd0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, reset-mid-lock sequence, then random traffic against a reference model.
module tb_data_mem_arbiter;
  localparam int AW  = 10;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req = 1'b0, core_wr = 1'b0, dbg_req = 1'b0, dbg_lock = 1'b0, dbg_wr = 1'b0;
  logic [AW-1:0] core_addr = '0, dbg_addr = '0;
  logic [31:0]   core_wdata = '0, dbg_wdata = '0, mem_rdata = '0;
  logic [2:0]    core_f3 = '0, dbg_f3 = '0;
  logic          core_gnt, core_stall, dbg_gnt, mem_ren, mem_wen;
  logic [31:0]   core_rdata, dbg_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_f3;

  int checks = 0;
  int failures = 0;

  // Reference model: lock flag, count of consecutive cycles debug has been refused, round-robin turn.
  logic m_locked = 1'b0;
  int   m_wait = 0;
  logic m_dbg_turn = 1'b0;
  logic last_cg = 1'b0, last_dg = 1'b0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.AddressWidth(AW), .StarveLimit(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_wr_en_i(core_wr), .core_addr_i(core_addr),
    .core_wr_data_i(core_wdata), .core_funct3_i(core_f3),
    .core_gnt_o(core_gnt), .core_stall_o(core_stall), .core_r_data_o(core_rdata),
    .dbg_req_i(dbg_req), .dbg_lock_i(dbg_lock), .dbg_wr_en_i(dbg_wr), .dbg_addr_i(dbg_addr),
    .dbg_wr_data_i(dbg_wdata), .dbg_funct3_i(dbg_f3),
    .dbg_gnt_o(dbg_gnt), .dbg_r_data_o(dbg_rdata),
    .mem_r_en_o(mem_ren), .mem_wr_en_o(mem_wen), .mem_addr_o(mem_addr),
    .mem_wr_data_o(mem_wdata), .mem_funct3_o(mem_f3), .mem_r_data_i(mem_rdata)
  );

  typedef struct {
    logic creq, cwr, dreq, dlock, dwr;
    logic cg, dg;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic creq, cwr, dreq, dlock, dwr, cg, dg);
    vec_t v;
    v.creq = creq; v.cwr = cwr; v.dreq = dreq; v.dlock = dlock; v.dwr = dwr;
    v.cg = cg; v.dg = dg;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected memory-side values follow from which port should own the memory.
  task automatic check_outputs(input string tag, input logic ecg, input logic edg);
    logic          e_ren, e_wen;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata;
    logic [2:0]    e_f3;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_f3 = '0;
    if (ecg) begin
      e_wen = core_wr; e_ren = !core_wr; e_addr = core_addr; e_wdata = core_wdata; e_f3 = core_f3;
    end else if (edg) begin
      e_wen = dbg_wr; e_ren = !dbg_wr; e_addr = dbg_addr; e_wdata = dbg_wdata; e_f3 = dbg_f3;
    end
    check({tag, "_gnt"}, 128'({core_gnt, dbg_gnt, core_stall}), 128'({ecg, edg, core_req & ~ecg}));
    check({tag, "_mux"},
          128'({mem_ren, mem_wen, mem_addr, mem_wdata, mem_f3, core_rdata, dbg_rdata}),
          128'({e_ren, e_wen, e_addr, e_wdata, e_f3,
                ecg ? mem_rdata : 32'd0, edg ? mem_rdata : 32'd0}));
  endtask

  task automatic check_reset_zero(input string tag);
    check(tag, 128'({core_gnt, dbg_gnt, core_stall, mem_ren, mem_wen, core_rdata, dbg_rdata}), 128'd0);
  endtask

  function automatic void model_grants(output logic cg, output logic dg);
    cg = 1'b0;
    dg = 1'b0;
    if (m_locked) begin
      dg = dbg_req;
    end else if (core_req && dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      dg = m_dbg_turn;
`else
      dg = (m_wait == LIM);
`endif
      cg = !dg;
    end else begin
      cg = core_req;
      dg = dbg_req;
    end
  endfunction

  function automatic void model_edge(input logic cg, input logic dg);
    if (core_req && dbg_req) m_dbg_turn = cg;
    m_wait   = (dbg_req && !dg) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
    m_locked = dg && dbg_lock;
  endfunction

  function automatic void model_reset();
    m_locked = 1'b0; m_wait = 0; m_dbg_turn = 1'b0;
    last_cg = 1'b0; last_dg = 1'b0;
  endfunction

  // Called at posedge+1 with inputs already driven; checks mid-cycle, advances the model, returns at next posedge+1.
  task automatic step(input string tag, input bit use_model, input logic ecg, input logic edg);
    logic cg, dg;
    #4;
    cg = ecg; dg = edg;
    if (use_model) model_grants(cg, dg);
    check_outputs(tag, cg, dg);
    model_edge(cg, dg);
    last_cg = cg; last_dg = dg;
    @(posedge clk);
    #1;
  endtask

  // Stalled core and waiting debug requests are held; everything else is fresh.
  task automatic drive_random();
    if (!(core_req && !last_cg)) begin
      core_req = ($urandom_range(0, 9) < 7); core_wr = 1'($urandom);
      core_addr = AW'($urandom); core_wdata = $urandom; core_f3 = 3'($urandom);
    end
    if (!(dbg_req && !last_dg)) begin
      dbg_req = ($urandom_range(0, 9) < 5); dbg_wr = 1'($urandom);
      dbg_addr = AW'($urandom); dbg_wdata = $urandom; dbg_f3 = 3'($urandom);
    end
    dbg_lock  = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  initial begin
    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 0, 0, 1, 0);
    tbl[2] = mk(0, 0, 1, 0, 1, 0, 1);
    for (int i = 3; i <= 6; i++) tbl[i] = mk(1, 0, 1, 0, 0, 1, 0);
    tbl[7] = mk(1, 0, 1, 0, 0, 0, 1);
    for (int i = 8; i <= 11; i++) tbl[i] = mk(1, 1, 1, 0, 0, 1, 0);
    tbl[12] = mk(1, 1, 1, 1, 0, 0, 1);
    for (int i = 13; i <= 17; i++) tbl[i] = mk(1, 1, 1, 1, 1, 0, 1);
    tbl[18] = mk(1, 1, 1, 0, 1, 0, 1);
    tbl[19] = mk(1, 0, 1, 0, 0, 1, 0);
    tbl[20] = mk(1, 0, 1, 1, 0, 1, 0);
    tbl[21] = mk(1, 0, 1, 1, 0, 1, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 1, 0, 0, 0, 1);

    core_req = 1'b1; dbg_req = 1'b1; mem_rdata = 32'h1234_5678;
    #3;
    check_reset_zero("in_reset");
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    core_addr = 10'h010; core_wdata = 32'h0BAD_F00D; core_f3 = 3'b010;
    dbg_addr  = 10'h3FC; dbg_wdata  = 32'hDEAD_BEEF; dbg_f3  = 3'b001;
`ifndef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 24; i++) begin
      core_req = tbl[i].creq; core_wr = tbl[i].cwr; dbg_req = tbl[i].dreq;
      dbg_lock = tbl[i].dlock; dbg_wr = tbl[i].dwr; mem_rdata = $urandom;
      step($sformatf("vec%0d", i), 1'b0, tbl[i].cg, tbl[i].dg);
    end
`else
    for (int i = 0; i < 6; i++) begin
      core_req = 1'b1; core_wr = 1'b0; dbg_req = 1'b1; dbg_lock = 1'b0; dbg_wr = 1'b0;
      mem_rdata = $urandom;
      step($sformatf("rr%0d", i), 1'b0, (i % 2) == 0, (i % 2) == 1);
    end
`endif

    // Take the lock, then hit reset asynchronously in the middle of a locked cycle.
    core_req = 1'b0; dbg_req = 1'b1; dbg_lock = 1'b1; dbg_wr = 1'b0;
    step("lock_take", 1'b0, 1'b0, 1'b1);
    core_req = 1'b1;
    step("lock_hold", 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_zero("rst_midlock");
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("after_rst", 1'b0, 1'b1, 1'b0);
    dbg_lock = 1'b0;
    step("after_rst2", 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      drive_random();
      step("rand", 1'b1, 1'b0, 1'b0);
    end

    core_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    step("idle_end", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
